// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a 1-cycle-latency data BRAM between the CPU and the UART loader,
// with starvation protection for the loader and an exclusive loader mode for upgrades.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upg_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic [DATA_W-1:0] uart_rdata,
    output logic              uart_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, CPU_RD, UART_RD} state_t;

    state_t            state;
    logic [CW-1:0]     starve_cnt;
    logic [DATA_W-1:0] cpu_rd_hold, uart_rd_hold;
    logic              idle, cpu_rd, uart_rd, force_uart, grant_cpu, grant_uart;

    // Grants are only possible in IDLE and never while reset is held.
    always_comb begin
        idle       = rst_n & (state == IDLE);
        cpu_rd     = rst_n & (state == CPU_RD);
        uart_rd    = rst_n & (state == UART_RD);
        force_uart = uart_req & (starve_cnt == CW'(STARVE_MAX));
        grant_cpu  = idle & cpu_req & ~upg_mode & ~force_uart;
        grant_uart = idle & uart_req & ~grant_cpu;
        mem_en     = grant_cpu | grant_uart;
        mem_we     = grant_cpu ? cpu_we : grant_uart & uart_we;
        mem_addr   = grant_cpu ? cpu_addr : grant_uart ? uart_addr : '0;
        mem_wdata  = grant_cpu ? cpu_wdata : grant_uart ? uart_wdata : '0;
        cpu_stall  = cpu_req & ~(grant_cpu & cpu_we) & ~cpu_rd;
        uart_ack   = uart_rd | (grant_uart & uart_we);
        cpu_rdata  = (state == CPU_RD) ? mem_rdata : cpu_rd_hold;
        uart_rdata = (state == UART_RD) ? mem_rdata : uart_rd_hold;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            cpu_rd_hold  <= '0;
            uart_rd_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= (grant_cpu & ~cpu_we) ? CPU_RD : (grant_uart & ~uart_we) ? UART_RD : IDLE;
                    if (grant_uart)
                        starve_cnt <= '0;
                    else if (uart_req && starve_cnt != CW'(STARVE_MAX))
                        starve_cnt <= starve_cnt + CW'(1);
                end
                CPU_RD: begin
                    cpu_rd_hold <= mem_rdata;
                    state       <= IDLE;
                end
                UART_RD: begin
                    uart_rd_hold <= mem_rdata;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vectors against the arbiter with a behavioural BRAM attached.
module tb_dmem_port_arbiter;
    logic        clk = 0;
    logic        rst_n, upg_mode, cpu_req, cpu_we, uart_req, uart_we;
    logic [13:0] cpu_addr, uart_addr, mem_addr;
    logic [31:0] cpu_wdata, uart_wdata, cpu_rdata, uart_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, uart_ack, mem_en, mem_we;
    logic [31:0] mem [0:16383];
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end

    dmem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .upg_mode(upg_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata), .uart_ack(uart_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [13:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic ldr(input logic req, input logic we, input logic [13:0] a, input logic [31:0] d);
        uart_req = req; uart_we = we; uart_addr = a; uart_wdata = d;
    endtask

    initial begin
        rst_n = 0; upg_mode = 0; mem_rdata = 0;
        cpu(1, 0, 14'h010, 0);
        ldr(1, 1, 14'h100, 32'h55);
        // Reset with both requesters active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_ack", uart_ack, 0);
            chk("rst_stall", cpu_stall, 1);
            tick();
        end
        rst_n = 1;
        cpu(1, 1, 14'h010, 32'hDEADBEEF);
        @(negedge clk);
        chk("first_grant_cpu_addr", mem_addr, 14'h010);
        chk("store_wdata", mem_wdata, 32'hDEADBEEF);
        chk("store_no_stall", cpu_stall, 0);
        chk("store_no_ack", uart_ack, 0);
        tick();
        ldr(0, 0, 0, 0);
        cpu(1, 0, 14'h010, 0);
        @(negedge clk);
        chk("load_issue_en", {mem_en, mem_we}, 2'b10);
        chk("load_stall", cpu_stall, 1);
        tick();
        @(negedge clk);
        chk("load_done_stall", cpu_stall, 0);
        chk("load_data", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_rd_no_issue", {mem_en, mem_addr}, 0);
        tick();
        cpu(0, 0, 0, 0);
        ldr(1, 1, 14'h100, 32'h55);
        @(negedge clk);
        chk("cpu_hold", cpu_rdata, 32'hDEADBEEF);
        chk("ldr_write_ack", uart_ack, 1);
        tick();
        // Starvation: loader must win on the 9th denied-then-forced cycle.
        ldr(1, 1, 14'h020, 32'hA5A5A5A5);
        for (int i = 1; i <= 9; i++) begin
            cpu(1, 1, 14'(14'h200 + i), 32'(i));
            @(negedge clk);
            chk($sformatf("starve_ack_%0d", i), uart_ack, i == 9);
            chk($sformatf("starve_stall_%0d", i), cpu_stall, i == 9);
            tick();
        end
        ldr(0, 0, 0, 0);
        @(negedge clk);
        chk("starve_cleared", dut.starve_cnt, 0);
        chk("cpu_back", cpu_stall, 0);
        tick();
        // Upgrade mode: loader exclusive, CPU held stalled.
        upg_mode = 1;
        cpu(1, 0, 14'h010, 0);
        for (int i = 0; i < 4; i++) begin
            ldr(1, 1, 14'(i), 32'h100 + 32'(i));
            @(negedge clk);
            chk($sformatf("upg_wr_ack_%0d", i), uart_ack, 1);
            chk($sformatf("upg_stall_%0d", i), cpu_stall, 1);
            tick();
        end
        ldr(1, 0, 14'h002, 0);
        @(negedge clk);
        chk("upg_rd_no_ack", uart_ack, 0);
        chk("upg_rd_issue", {mem_en, mem_we, mem_addr}, {2'b10, 14'h002});
        tick();
        @(negedge clk);
        chk("upg_rd_ack", uart_ack, 1);
        chk("upg_rd_data", uart_rdata, 32'h102);
        chk("upg_rd_stall", cpu_stall, 1);
        tick();
        ldr(0, 0, 0, 0);
        @(negedge clk);
        chk("upg_idle_stall", cpu_stall, 1);
        chk("upg_idle_no_en", mem_en, 0);
        tick();
        // upg_mode rising while a CPU read is in flight.
        upg_mode = 0;
        cpu(1, 0, 14'h010, 0);
        @(negedge clk);
        chk("mid_load_stall", cpu_stall, 1);
        tick();
        upg_mode = 1;
        @(negedge clk);
        chk("mid_load_done", cpu_stall, 0);
        chk("mid_load_data", cpu_rdata, 32'hDEADBEEF);
        tick();
        cpu(1, 0, 14'h003, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("upg_block_%0d", i), {mem_en, cpu_stall}, 2'b01);
            tick();
        end
        upg_mode = 0;
        @(negedge clk);
        chk("unblock_issue", {mem_en, cpu_stall}, 2'b11);
        tick();
        @(negedge clk);
        chk("unblock_data", {cpu_stall, cpu_rdata}, {1'b0, 32'h103});
        tick();
        // Reset in the middle of a CPU read aborts it.
        cpu(1, 0, 14'h002, 0);
        @(negedge clk);
        chk("abort_issue_stall", cpu_stall, 1);
        tick();
        rst_n = 0;
        @(negedge clk);
        chk("abort_stall", cpu_stall, 1);
        chk("abort_quiet", {mem_en, uart_ack}, 0);
        tick();
        rst_n = 1;
        cpu(0, 0, 0, 0);
        @(negedge clk);
        chk("abort_idle", dut.state, 0);
        chk("abort_cpu_hold", cpu_rdata, 0);
        chk("abort_uart_hold", uart_rdata, 0);
        chk("abort_no_stall", cpu_stall, 0);
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
